regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
`timescale 1ns/1ps
// Writeback arbiter: merges NLANES lane writebacks onto NWPORTS register-file write ports, with one skid entry per lane.
// Define WBARB_RR_EN for a round-robin lane order within each class; otherwise lane 0 always goes first.
module regfile_wb_arbiter #(
  parameter int XLEN    = 64,
  parameter int NLANES  = 4,
  parameter int NWPORTS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NLANES-1:0]       RegWriteW,
  input  logic [5*NLANES-1:0]     RdW,
  input  logic [XLEN*NLANES-1:0]  ResultW,
  output logic [NWPORTS-1:0]      we,
  output logic [5*NWPORTS-1:0]    wa,
  output logic [XLEN*NWPORTS-1:0] wd,
  output logic [NLANES-1:0]       StallWB,
  output logic [31:0]             PendingMask
);
  localparam int LW = $clog2(NLANES);

  logic [NLANES-1:0]         skid_v;
  logic [4:0]                skid_rd   [NLANES];
  logic [XLEN-1:0]           skid_data [NLANES];

  logic [4:0]                rd_in   [NLANES];
  logic [XLEN-1:0]           data_in [NLANES];
  logic [NLANES-1:0]         req_eff;
  logic [NLANES-1:0]         survive;
  logic [NLANES-1:0]         kill;
  logic [NLANES-1:0]         gnt_skid;
  logic [NLANES-1:0]         gnt_new;
  logic [NWPORTS-1:0]        we_c;
  logic [5*NWPORTS-1:0]      wa_c;
  logic [XLEN*NWPORTS-1:0]   wd_c;
  logic [LW-1:0]             ptr;
  logic [LW-1:0]             lane;
  logic                      cand;
  int                        n_grant;

`ifdef WBARB_RR_EN
  logic [LW-1:0]             last_lane;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (|we_c) begin
      ptr <= last_lane + 1'b1;
    end
  end
`else
  assign ptr = '0;
`endif

  // A stalled lane's inputs are ignored; x0 writes are dropped outright.
  always_comb begin
    for (int i = 0; i < NLANES; i++) begin
      rd_in[i]   = RdW[5*i +: 5];
      data_in[i] = ResultW[XLEN*i +: XLEN];
      req_eff[i] = RegWriteW[i] && !skid_v[i] && (rd_in[i] != 5'd0);
    end
  end

  // Same-rd collisions: highest new lane wins, and it supersedes any buffered copy.
  always_comb begin
    survive = req_eff;
    kill    = '0;
    for (int i = 0; i < NLANES; i++) begin
      for (int j = 0; j < NLANES; j++) begin
        if (j > i && req_eff[j] && rd_in[j] == rd_in[i]) begin
          survive[i] = 1'b0;
        end
      end
    end
    for (int k = 0; k < NLANES; k++) begin
      for (int i = 0; i < NLANES; i++) begin
        if (survive[i] && skid_v[k] && rd_in[i] == skid_rd[k]) begin
          kill[k] = 1'b1;
        end
      end
    end
  end

  // Walk skid entries first, then new requests, each starting at the pointer lane.
  always_comb begin
    we_c     = '0;
    wa_c     = '0;
    wd_c     = '0;
    gnt_skid = '0;
    gnt_new  = '0;
    n_grant  = 0;
    lane     = '0;
    cand     = 1'b0;
`ifdef WBARB_RR_EN
    last_lane = ptr;
`endif
    for (int p = 0; p < 2*NLANES; p++) begin
      lane = ptr + LW'(p % NLANES);
      if (p < NLANES) cand = skid_v[lane] && !kill[lane];
      else            cand = survive[lane];
      if (cand && n_grant < NWPORTS) begin
        for (int w = 0; w < NWPORTS; w++) begin
          if (w == n_grant) begin
            we_c[w] = 1'b1;
            if (p < NLANES) begin
              wa_c[5*w +: 5]       = skid_rd[lane];
              wd_c[XLEN*w +: XLEN] = skid_data[lane];
            end else begin
              wa_c[5*w +: 5]       = rd_in[lane];
              wd_c[XLEN*w +: XLEN] = data_in[lane];
            end
          end
        end
        if (p < NLANES) gnt_skid[lane] = 1'b1;
        else            gnt_new[lane]  = 1'b1;
`ifdef WBARB_RR_EN
        last_lane = lane;
`endif
        n_grant = n_grant + 1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_v <= '0;
      for (int k = 0; k < NLANES; k++) begin
        skid_rd[k]   <= '0;
        skid_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NLANES; k++) begin
        if (gnt_skid[k] || kill[k]) begin
          skid_v[k] <= 1'b0;
        end else if (survive[k] && !gnt_new[k]) begin
          skid_v[k]    <= 1'b1;
          skid_rd[k]   <= rd_in[k];
          skid_data[k] <= data_in[k];
        end
      end
    end
  end

  always_comb begin
    PendingMask = '0;
    for (int k = 0; k < NLANES; k++) begin
      if (skid_v[k]) PendingMask[skid_rd[k]] = 1'b1;
    end
  end

  // Write ports are gated by reset so they drop at once, before the flops settle.
  assign we      = reset ? we_c : '0;
  assign wa      = reset ? wa_c : '0;
  assign wd      = reset ? wd_c : '0;
  assign StallWB = skid_v;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for regfile_wb_arbiter: stimulus queues per-cycle expected outputs, a monitor compares at negedge.
module tb_regfile_wb_arbiter;
  logic         clk;
  logic         reset;
  logic [3:0]   RegWriteW;
  logic [19:0]  RdW;
  logic [255:0] ResultW;
  logic [1:0]   we;
  logic [9:0]   wa;
  logic [127:0] wd;
  logic [3:0]   StallWB;
  logic [31:0]  PendingMask;

  typedef struct {
    int           tag;
    logic [1:0]   we;
    logic [9:0]   wa;
    logic [127:0] wd;
    logic [3:0]   stall;
    logic [31:0]  pm;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  regfile_wb_arbiter dut (
    .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .we(we), .wa(wa), .wd(wd), .StallWB(StallWB), .PendingMask(PendingMask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int tag, input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s tag=%0d actual=%h required=%h", name, tag, act, req);
    end
  endtask

  task automatic clear_in();
    RegWriteW = '0;
    RdW       = '0;
    ResultW   = '0;
  endtask

  task automatic lane_req(input int l, input logic [4:0] rd, input logic [63:0] d);
    RegWriteW[l]     = 1'b1;
    RdW[5*l +: 5]    = rd;
    ResultW[64*l +: 64] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic expect_cyc(input int tag, input logic [1:0] e_we, input logic [4:0] wa1, input logic [4:0] wa0,
                            input logic [63:0] wd1, input logic [63:0] wd0, input logic [3:0] st, input logic [31:0] pm);
    exp_t e;
    e.tag = tag; e.we = e_we; e.wa = {wa1, wa0}; e.wd = {wd1, wd0}; e.stall = st; e.pm = pm;
    exp_q.push_back(e);
  endtask

  task automatic expect_idle(input int tag);
    expect_cyc(tag, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 4'b0000, 32'd0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk(e.tag, "we",    we,          e.we);
          chk(e.tag, "wa",    wa,          e.wa);
          chk(e.tag, "wd",    wd,          e.wd);
          chk(e.tag, "stall", StallWB,     e.stall);
          chk(e.tag, "pmask", PendingMask, e.pm);
        end else begin
          chk(-1, "unexpected_write", we, 2'b00);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    clear_in();
    lane_req(0, 5'd5, 64'hFF);
    repeat (2) @(posedge clk);
    #1;
    chk(0, "rst_we",    we,          2'b00);
    chk(0, "rst_stall", StallWB,     4'b0000);
    chk(0, "rst_pmask", PendingMask, 32'd0);
    clear_in();
    reset = 1'b1;

    // two lanes, two ports, zero latency
    step(); lane_req(0, 5'd5, 64'h11); lane_req(1, 5'd6, 64'h22);
    expect_cyc(1, 2'b11, 5'd6, 5'd5, 64'h22, 64'h11, 4'b0000, 32'd0);
    step(); expect_idle(2);

    // x0 discarded
    step(); lane_req(0, 5'd0, 64'hFF);
    expect_idle(3);
    step(); expect_idle(4);

    // same-rd collision: lane 3 wins, lane 1 not buffered
    step(); lane_req(1, 5'd7, 64'hA); lane_req(3, 5'd7, 64'hB);
    expect_cyc(5, 2'b01, 5'd0, 5'd7, 64'd0, 64'hB, 4'b0000, 32'd0);
    step(); expect_idle(6);

    // four lanes: two granted, two buffered then drained
    step(); lane_req(0, 5'd1, 64'd1); lane_req(1, 5'd2, 64'd2); lane_req(2, 5'd3, 64'd3); lane_req(3, 5'd4, 64'd4);
    expect_cyc(7, 2'b11, 5'd2, 5'd1, 64'd2, 64'd1, 4'b0000, 32'd0);
    step(); expect_cyc(8, 2'b11, 5'd4, 5'd3, 64'd4, 64'd3, 4'b1100, 32'h18);
    step(); expect_idle(9);

    // skid entries beat new requests; stalled lane 2 input ignored
    step(); lane_req(0, 5'd1, 64'd5); lane_req(1, 5'd2, 64'd6); lane_req(2, 5'd3, 64'd7); lane_req(3, 5'd4, 64'd8);
    expect_cyc(10, 2'b11, 5'd2, 5'd1, 64'd6, 64'd5, 4'b0000, 32'd0);
    step(); lane_req(0, 5'd12, 64'h12); lane_req(1, 5'd13, 64'h13); lane_req(2, 5'd14, 64'h14);
    expect_cyc(11, 2'b11, 5'd4, 5'd3, 64'd8, 64'd7, 4'b1100, 32'h18);
    step(); expect_cyc(12, 2'b11, 5'd13, 5'd12, 64'h13, 64'h12, 4'b0011, 32'h3000);
    step(); expect_idle(13);

    // new write to x9 kills buffered x9 in lane 2
    step(); lane_req(0, 5'd10, 64'd1); lane_req(1, 5'd11, 64'd2); lane_req(2, 5'd9, 64'h5);
    expect_cyc(14, 2'b11, 5'd11, 5'd10, 64'd2, 64'd1, 4'b0000, 32'd0);
    step(); lane_req(0, 5'd9, 64'h6);
    expect_cyc(15, 2'b01, 5'd0, 5'd9, 64'd0, 64'h6, 4'b0100, 32'h200);
    step(); expect_idle(16);

    // mid-cycle reset with buffered writes
    step(); lane_req(0, 5'd1, 64'h31); lane_req(1, 5'd2, 64'h32); lane_req(2, 5'd3, 64'h33); lane_req(3, 5'd4, 64'h34);
    expect_cyc(17, 2'b11, 5'd2, 5'd1, 64'h32, 64'h31, 4'b0000, 32'd0);
    step(); lane_req(0, 5'd20, 64'h40); lane_req(1, 5'd21, 64'h41); lane_req(2, 5'd22, 64'h42); lane_req(3, 5'd23, 64'h43);
    #1;
    chk(18, "pre_rst_we",    we,      2'b11);
    chk(18, "pre_rst_stall", StallWB, 4'b1100);
    #1;
    reset = 1'b0;
    #1;
    chk(18, "mid_rst_we",    we,          2'b00);
    chk(18, "mid_rst_stall", StallWB,     4'b0000);
    chk(18, "mid_rst_pmask", PendingMask, 32'd0);
    chk(18, "mid_rst_wa",    wa,          10'd0);
    step(); reset = 1'b1;
    expect_idle(19);
    step(); expect_idle(20);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
